// File: rtl/pixel_scan_sequencer.sv
// Stonyman frame-capture sequencer: walks row/column addresses, waits the analog
// settle time, requests one ADC capture per pixel and waits for its acknowledge.
module pixel_scan_sequencer #(
    parameter int MAX_RES        = 112,
    parameter int ADDR_BITS      = 7,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 frame_start,
    input  logic                 frame_abort,
    input  logic [ADDR_BITS-1:0] cfg_resolution,
    input  logic [2:0]           cfg_stride,
    input  logic [7:0]           settle_counts,
    input  logic                 adc_capture_done,
    output logic [ADDR_BITS-1:0] pix_row,
    output logic [ADDR_BITS-1:0] pix_col,
    output logic                 addr_strobe,
    output logic                 adc_capture_start,
    output logic                 newline_sample,
    output logic                 frame_busy,
    output logic                 frame_done,
    output logic                 err_overrun,
    output logic                 err_timeout
);

    localparam int W        = ADDR_BITS + 1;
    localparam int TMO_BITS = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [ADDR_BITS-1:0] MAX_RES_A = ADDR_BITS'(MAX_RES);
    localparam logic [TMO_BITS-1:0]  TMO_LAST  = TMO_BITS'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_ADDR,
        SETTLE,
        CAPTURE_REQ,
        WAIT_DONE,
        ADVANCE,
        DONE
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_BITS-1:0]  row_q, row_d, col_q, col_d, res_q, res_d;
    logic [2:0]            stride_q, stride_d;
    logic [7:0]            settle_q, settle_d, settle_cnt_q, settle_cnt_d;
    logic [TMO_BITS-1:0]   tmo_q, tmo_d;
    logic                  timeout_hit;

    logic [ADDR_BITS-1:0]  pix_row_q, pix_row_d, pix_col_q, pix_col_d;
    logic                  addr_strobe_q, addr_strobe_d;
    logic                  start_q, start_d;
    logic                  newline_q, newline_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_overrun_q, err_overrun_d;
    logic                  err_timeout_q, err_timeout_d;

    // One extra bit so stepping past the last pixel cannot wrap back into range.
    logic [W-1:0] col_sum, row_sum;
    assign col_sum = {1'b0, col_q} + W'(stride_q);
    assign row_sum = {1'b0, row_q} + W'(stride_q);

    // State register and registered outputs.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register sampling the pre-edge values.
        if (reset) begin
            state_q       <= IDLE;
            row_q         <= '0;
            col_q         <= '0;
            res_q         <= '0;
            stride_q      <= '0;
            settle_q      <= '0;
            settle_cnt_q  <= '0;
            tmo_q         <= '0;
            pix_row_q     <= '0;
            pix_col_q     <= '0;
            addr_strobe_q <= 1'b0;
            start_q       <= 1'b0;
            newline_q     <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_overrun_q <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            row_q         <= row_d;
            col_q         <= col_d;
            res_q         <= res_d;
            stride_q      <= stride_d;
            settle_q      <= settle_d;
            settle_cnt_q  <= settle_cnt_d;
            tmo_q         <= tmo_d;
            pix_row_q     <= pix_row_d;
            pix_col_q     <= pix_col_d;
            addr_strobe_q <= addr_strobe_d;
            start_q       <= start_d;
            newline_q     <= newline_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            err_overrun_q <= err_overrun_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    // Next-state and counter logic.
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        state_d      = state_q;
        row_d        = row_q;
        col_d        = col_q;
        res_d        = res_q;
        stride_d     = stride_q;
        settle_d     = settle_q;
        settle_cnt_d = settle_cnt_q;
        tmo_d        = tmo_q;
        timeout_hit  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (frame_start) begin
                    if (cfg_resolution == '0)
                        res_d = ADDR_BITS'(1);
                    else if (cfg_resolution > MAX_RES_A)
                        res_d = MAX_RES_A;
                    else
                        res_d = cfg_resolution;
                    stride_d = (cfg_stride == 3'd0) ? 3'd1 : cfg_stride;
                    settle_d = settle_counts;
                    row_d    = '0;
                    col_d    = '0;
                    state_d  = LOAD_ADDR;
                end
            end
            LOAD_ADDR: begin
                if (settle_q == 8'd0) begin
                    state_d = CAPTURE_REQ;
                end else begin
                    settle_cnt_d = settle_q - 8'd1;
                    state_d      = SETTLE;
                end
            end
            SETTLE: begin
                if (settle_cnt_q == 8'd0)
                    state_d = CAPTURE_REQ;
                else
                    settle_cnt_d = settle_cnt_q - 8'd1;
            end
            CAPTURE_REQ: begin
                tmo_d   = '0;
                state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (adc_capture_done) begin
                    state_d = ADVANCE;
                end else if (tmo_q == TMO_LAST) begin
                    timeout_hit = 1'b1;
                    state_d     = IDLE;
                end else begin
                    tmo_d = tmo_q + TMO_BITS'(1);
                end
            end
            ADVANCE: begin
                if (col_sum >= {1'b0, res_q}) begin
                    col_d = '0;
                    if (row_sum >= {1'b0, res_q}) begin
                        state_d = DONE;
                    end else begin
                        row_d   = row_sum[ADDR_BITS-1:0];
                        state_d = LOAD_ADDR;
                    end
                end else begin
                    col_d   = col_sum[ADDR_BITS-1:0];
                    state_d = LOAD_ADDR;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Abort takes priority over an acknowledge, a timeout or completion.
        if (frame_abort && state_q != IDLE) begin
            state_d     = IDLE;
            timeout_hit = 1'b0;
        end
    end

    // Output decode from the next state, so each output lines up with its state.
    always_comb begin
        addr_strobe_d = (state_d == LOAD_ADDR);
        start_d       = (state_d == CAPTURE_REQ);
        newline_d     = start_d && (col_d == '0);
        busy_d        = (state_d != IDLE) && (state_d != DONE);
        done_d        = (state_d == DONE);
        pix_row_d     = addr_strobe_d ? row_d : pix_row_q;
        pix_col_d     = addr_strobe_d ? col_d : pix_col_q;
        err_overrun_d = err_overrun_q | (frame_start && state_q != IDLE);
        err_timeout_d = err_timeout_q | timeout_hit;
    end

    assign pix_row           = pix_row_q;
    assign pix_col           = pix_col_q;
    assign addr_strobe       = addr_strobe_q;
    assign adc_capture_start = start_q;
    assign newline_sample    = newline_q;
    assign frame_busy        = busy_q;
    assign frame_done        = done_q;
    assign err_overrun       = err_overrun_q;
    assign err_timeout       = err_timeout_q;

endmodule
